branch_checkpoint_table: RTL and testbench

- Snapshots rename state for every in-flight branch: physical-register free lists, translation table and ROB tail.
- Returns a snapshot on the branch_recovery interface when the hazard controller restores after a branch-unit mispredict.
- Sits beside rename/dispatch: written when a branch is dispatched, read and released when the branch resolves.

---
 rtl/branch_checkpoint_table.sv | 209 ++++++++++++++++++++
 tb/tb_branch_checkpoint_table.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_checkpoint_table.sv
// branch_checkpoint_table
// Keeps one rename-state snapshot (free lists, translation maps, ROB tail) per
// in-flight branch. Entries are allocated in program order at the tail,
// released out of order on resolve, and retired from the head one per cycle.
// A mispredict discards the resolving entry and every younger one, and the
// stored snapshot of the resolving entry is presented combinationally so the
// hazard controller can restore in the same cycle.

`ifndef NUM_D_REG
`define NUM_D_REG 64
`endif
`ifndef NUM_S_REG
`define NUM_S_REG 16
`endif
`ifndef ROB_LENGTH
`define ROB_LENGTH 32
`endif

module branch_checkpoint_table #(
    parameter int CP_DEPTH = 4,
    parameter int D_REG    = `NUM_D_REG,
    parameter int S_REG    = `NUM_S_REG,
    parameter int ROB_LEN  = `ROB_LENGTH,
    localparam int IDW     = $clog2(CP_DEPTH),
    localparam int CW      = IDW + 1,
    localparam int DW      = $clog2(D_REG),
    localparam int SW      = $clog2(S_REG),
    localparam int RW      = $clog2(ROB_LEN)
) (
    input  logic                  clk,
    input  logic                  rst,
    // checkpoint capture
    input  logic                  alloc_valid,
    input  logic [D_REG-1:0]      alloc_r_free_list,
    input  logic [S_REG-1:0]      alloc_s_free_list,
    input  logic [15:0][DW-1:0]   alloc_d_translation,
    input  logic [SW-1:0]         alloc_s_translation,
    input  logic [RW-1:0]         alloc_rob_tail,
    output logic [IDW-1:0]        alloc_id,
    output logic                  full,
    output logic                  empty,
    // branch resolution
    input  logic                  resolve_valid,
    input  logic [IDW-1:0]        resolve_id,
    input  logic                  resolve_mispredict,
    // registers released by commit
    input  logic                  free_valid,
    input  logic [DW-1:0]         free_reg,
    // recovery snapshot of entry resolve_id
    output logic [D_REG-1:0]      frl_r_cp,
    output logic [S_REG-1:0]      frl_s_cp,
    output logic [15:0][DW-1:0]   tt_d_cp,
    output logic [SW-1:0]         tt_s_cp,
    output logic [RW-1:0]         rob_tail_cp
);

    // Payload storage
    logic [CP_DEPTH-1:0][D_REG-1:0]     r_free_r;
    logic [CP_DEPTH-1:0][S_REG-1:0]     s_free_r;
    logic [CP_DEPTH-1:0][15:0][DW-1:0]  tt_d_r;
    logic [CP_DEPTH-1:0][SW-1:0]        tt_s_r;
    logic [CP_DEPTH-1:0][RW-1:0]        rob_tail_r;

    // Bookkeeping
    logic [CP_DEPTH-1:0]  valid_r;
    logic [IDW-1:0]       head_r;
    logic [IDW-1:0]       tail_r;
    logic [CW-1:0]        count_r;
    logic                 full_r;
    logic                 empty_r;

    // Next-state signals
    logic                 correct_s;
    logic                 mispredict_s;
    logic                 alloc_s;
    logic [IDW-1:0]       resolve_pos_s;
    logic [CP_DEPTH-1:0]  valid_mid_s;
    logic [IDW-1:0]       tail_mid_s;
    logic [CW-1:0]        count_mid_s;
    logic [CP_DEPTH-1:0]  valid_next_s;
    logic [IDW-1:0]       tail_next_s;
    logic [CW-1:0]        count_alloc_s;
    logic [IDW-1:0]       head_next_s;
    logic [CW-1:0]        count_next_s;
    logic [CP_DEPTH-1:0][D_REG-1:0] r_free_next_s;

    // Resolve, allocate and retire decisions for this cycle
    always_comb begin
        correct_s     = resolve_valid && !resolve_mispredict && valid_r[resolve_id];
        mispredict_s  = resolve_valid && resolve_mispredict && valid_r[resolve_id];
        // A mispredict request blocks allocation even if its id is stale
        alloc_s       = alloc_valid && !full_r && !(resolve_valid && resolve_mispredict);
        // Position of the resolving entry counted from the oldest live entry
        resolve_pos_s = resolve_id - head_r;

        valid_mid_s   = valid_r;
        tail_mid_s    = tail_r;
        count_mid_s   = count_r;
        if (correct_s) begin
            valid_mid_s[resolve_id] = 1'b0;
        end else if (mispredict_s) begin
            // Age order is measured from head so a full ring is handled too
            for (int i = 0; i < CP_DEPTH; i++) begin
                if ((IDW'(i) - head_r) >= resolve_pos_s) begin
                    valid_mid_s[i] = 1'b0;
                end else begin
                    valid_mid_s[i] = valid_r[i];
                end
            end
            tail_mid_s  = resolve_id;
            count_mid_s = {1'b0, resolve_pos_s};
        end else begin
            valid_mid_s = valid_r;
        end

        valid_next_s  = valid_mid_s;
        tail_next_s   = tail_mid_s;
        count_alloc_s = count_mid_s;
        if (alloc_s) begin
            valid_next_s[tail_r] = 1'b1;
            tail_next_s          = tail_r + IDW'(1);
            count_alloc_s        = count_mid_s + CW'(1);
        end else begin
            tail_next_s          = tail_mid_s;
        end

        // Retire looks at post-resolve state; an entry allocated this cycle
        // can never be the head of a non-empty ring, so it is never retired
        if ((count_mid_s != CW'(0)) && !valid_mid_s[head_r]) begin
            head_next_s  = head_r + IDW'(1);
            count_next_s = count_alloc_s - CW'(1);
        end else begin
            head_next_s  = head_r;
            count_next_s = count_alloc_s;
        end
    end

    // Data free-list next value: capture on alloc, then forward released registers
    always_comb begin
        r_free_next_s = r_free_r;
        for (int i = 0; i < CP_DEPTH; i++) begin
            if (alloc_s && (tail_r == IDW'(i))) begin
                r_free_next_s[i] = alloc_r_free_list;
            end else begin
                r_free_next_s[i] = r_free_r[i];
            end
            if (free_valid && (valid_mid_s[i] || (alloc_s && (tail_r == IDW'(i))))) begin
                r_free_next_s[i][free_reg] = 1'b1;
            end else begin
                r_free_next_s[i] = r_free_next_s[i];
            end
        end
    end

    // Pointer, occupancy and status-flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= '0;
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
            full_r  <= 1'b0;
            empty_r <= 1'b1;
        end else begin
            valid_r <= valid_next_s;
            head_r  <= head_next_s;
            tail_r  <= tail_next_s;
            count_r <= count_next_s;
            full_r  <= (count_next_s == CW'(CP_DEPTH));
            empty_r <= (count_next_s == CW'(0));
        end
    end

    // Snapshot payload registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_free_r   <= '0;
            s_free_r   <= '0;
            tt_d_r     <= '0;
            tt_s_r     <= '0;
            rob_tail_r <= '0;
        end else begin
            r_free_r <= r_free_next_s;
            if (alloc_s) begin
                s_free_r[tail_r]   <= alloc_s_free_list;
                tt_d_r[tail_r]     <= alloc_d_translation;
                tt_s_r[tail_r]     <= alloc_s_translation;
                rob_tail_r[tail_r] <= alloc_rob_tail;
            end else begin
                s_free_r   <= s_free_r;
                tt_d_r     <= tt_d_r;
                tt_s_r     <= tt_s_r;
                rob_tail_r <= rob_tail_r;
            end
        end
    end

    assign alloc_id    = tail_r;
    assign full        = full_r;
    assign empty       = empty_r;

    // Zero-latency recovery read of the resolving entry
    assign frl_r_cp    = r_free_r[resolve_id];
    assign frl_s_cp    = s_free_r[resolve_id];
    assign tt_d_cp     = tt_d_r[resolve_id];
    assign tt_s_cp     = tt_s_r[resolve_id];
    assign rob_tail_cp = rob_tail_r[resolve_id];

endmodule

// File: tb/tb_branch_checkpoint_table.sv
// Directed testbench for branch_checkpoint_table.
module tb_branch_checkpoint_table;

    localparam int DR  = 64;
    localparam int SR  = 16;
    localparam int DW  = 6;
    localparam int SW  = 4;
    localparam int RW  = 5;
    localparam int IDW = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic                alloc_valid;
    logic [DR-1:0]       alloc_r_free_list;
    logic [SR-1:0]       alloc_s_free_list;
    logic [15:0][DW-1:0] alloc_d_translation;
    logic [SW-1:0]       alloc_s_translation;
    logic [RW-1:0]       alloc_rob_tail;
    logic [IDW-1:0]      alloc_id;
    logic                full;
    logic                empty;
    logic                resolve_valid;
    logic [IDW-1:0]      resolve_id;
    logic                resolve_mispredict;
    logic                free_valid;
    logic [DW-1:0]       free_reg;
    logic [DR-1:0]       frl_r_cp;
    logic [SR-1:0]       frl_s_cp;
    logic [15:0][DW-1:0] tt_d_cp;
    logic [SW-1:0]       tt_s_cp;
    logic [RW-1:0]       rob_tail_cp;

    int errors = 0;
    int checks = 0;

    branch_checkpoint_table #(.CP_DEPTH(4), .D_REG(DR), .S_REG(SR), .ROB_LEN(32)) dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_r_free_list(alloc_r_free_list),
        .alloc_s_free_list(alloc_s_free_list), .alloc_d_translation(alloc_d_translation),
        .alloc_s_translation(alloc_s_translation), .alloc_rob_tail(alloc_rob_tail),
        .alloc_id(alloc_id), .full(full), .empty(empty),
        .resolve_valid(resolve_valid), .resolve_id(resolve_id),
        .resolve_mispredict(resolve_mispredict),
        .free_valid(free_valid), .free_reg(free_reg),
        .frl_r_cp(frl_r_cp), .frl_s_cp(frl_s_cp), .tt_d_cp(tt_d_cp),
        .tt_s_cp(tt_s_cp), .rob_tail_cp(rob_tail_cp)
    );

    always #5 clk = ~clk;

    // Translation-map pattern tied to the ROB tail value of a snapshot
    function automatic logic [15:0][DW-1:0] mk_tt(input logic [RW-1:0] rob);
        logic [15:0][DW-1:0] t;
        for (int j = 0; j < 16; j++) t[j] = DW'(rob) + DW'(j);
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_valid = 1'b0; alloc_r_free_list = '0; alloc_s_free_list = '0;
        alloc_d_translation = '0; alloc_s_translation = '0; alloc_rob_tail = '0;
        resolve_valid = 1'b0; resolve_id = '0; resolve_mispredict = 1'b0;
        free_valid = 1'b0; free_reg = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic alloc_one(input logic [RW-1:0] rob);
        alloc_valid = 1'b1;
        alloc_r_free_list = {DR{1'b1}};
        alloc_s_free_list = {11'd0, rob};
        alloc_d_translation = mk_tt(rob);
        alloc_s_translation = rob[SW-1:0];
        alloc_rob_tail = rob;
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        #7;
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b expected 0", full); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %0b expected 1", empty); end
        checks++; if (alloc_id !== 2'd0) begin errors++; $display("FAIL reset_alloc_id: got %0d expected 0", alloc_id); end
        checks++; if (rob_tail_cp !== 5'd0 || frl_r_cp !== 64'd0 || tt_d_cp !== '0) begin
            errors++; $display("FAIL reset_recovery: got rob %0d frl %0h expected 0", rob_tail_cp, frl_r_cp); end
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_fill();
        logic [RW-1:0] robs [4];
        robs = '{5'd3, 5'd5, 5'd7, 5'd9};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            checks++; if (alloc_id !== IDW'(i)) begin errors++; $display("FAIL fill_alloc_id: got %0d expected %0d", alloc_id, i); end
            alloc_one(robs[i]);
        end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full: got %0b expected 1", full); end
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL fill_empty: got %0b expected 0", empty); end
        for (int i = 0; i < 4; i++) begin
            resolve_id = IDW'(i);
            #1;
            checks++; if (rob_tail_cp !== robs[i] || tt_d_cp !== mk_tt(robs[i])) begin
                errors++; $display("FAIL fill_read: id %0d got rob %0d expected %0d", i, rob_tail_cp, robs[i]); end
        end
        alloc_one(5'd31);
        resolve_id = 2'd0;
        #1;
        checks++; if (alloc_id !== 2'd0 || dut.count_r !== 3'd4) begin
            errors++; $display("FAIL fill_ignored: got tail %0d count %0d expected 0 4", alloc_id, dut.count_r); end
        checks++; if (rob_tail_cp !== 5'd3) begin errors++; $display("FAIL fill_no_overwrite: got %0d expected 3", rob_tail_cp); end
    endtask

    // Continues from the full table left by test_fill
    task automatic test_correct_resolve();
        resolve_valid = 1'b1; resolve_mispredict = 1'b0; resolve_id = 2'd1;
        tick();
        checks++; if (dut.head_r !== 2'd0 || dut.count_r !== 3'd4) begin
            errors++; $display("FAIL ooo_resolve: got head %0d count %0d expected 0 4", dut.head_r, dut.count_r); end
        resolve_id = 2'd0;
        tick();
        resolve_valid = 1'b0;
        checks++; if (dut.head_r !== 2'd1 || dut.count_r !== 3'd3 || full !== 1'b0) begin
            errors++; $display("FAIL retire1: got head %0d count %0d full %0b expected 1 3 0", dut.head_r, dut.count_r, full); end
        tick();
        checks++; if (dut.head_r !== 2'd2 || dut.count_r !== 3'd2) begin
            errors++; $display("FAIL retire2: got head %0d count %0d expected 2 2", dut.head_r, dut.count_r); end
    endtask

    task automatic test_mispredict();
        do_reset();
        alloc_one(5'd3); alloc_one(5'd5); alloc_one(5'd7); alloc_one(5'd9);
        resolve_valid = 1'b1; resolve_mispredict = 1'b1; resolve_id = 2'd1;
        #1;
        checks++; if (rob_tail_cp !== 5'd5 || tt_d_cp !== mk_tt(5'd5) || tt_s_cp !== 4'd5 || frl_s_cp !== 16'd5) begin
            errors++; $display("FAIL mp_same_cycle: got rob %0d tt_s %0d expected 5 5", rob_tail_cp, tt_s_cp); end
        tick();
        resolve_valid = 1'b0; resolve_mispredict = 1'b0;
        checks++; if (alloc_id !== 2'd1 || dut.count_r !== 3'd1) begin
            errors++; $display("FAIL mp_ptrs: got tail %0d count %0d expected 1 1", alloc_id, dut.count_r); end
        checks++; if (dut.valid_r !== 4'b0001 || full !== 1'b0 || empty !== 1'b0) begin
            errors++; $display("FAIL mp_valid: got %b full %0b empty %0b expected 0001 0 0", dut.valid_r, full, empty); end
    endtask

    task automatic test_mispredict_alloc();
        do_reset();
        alloc_one(5'd3); alloc_one(5'd5);
        resolve_valid = 1'b1; resolve_mispredict = 1'b1; resolve_id = 2'd1;
        alloc_valid = 1'b1; alloc_rob_tail = 5'd20; alloc_d_translation = mk_tt(5'd20);
        tick();
        idle();
        resolve_id = 2'd1;
        #1;
        checks++; if (alloc_id !== 2'd1 || dut.count_r !== 3'd1 || dut.valid_r !== 4'b0001) begin
            errors++; $display("FAIL mp_alloc_drop: got tail %0d count %0d valid %b expected 1 1 0001", alloc_id, dut.count_r, dut.valid_r); end
        checks++; if (rob_tail_cp !== 5'd5) begin errors++; $display("FAIL mp_alloc_payload: got %0d expected 5", rob_tail_cp); end
    endtask

    task automatic test_free_forward();
        do_reset();
        alloc_valid = 1'b1; alloc_r_free_list = '0; alloc_rob_tail = 5'd1;
        free_valid = 1'b1; free_reg = 6'd7;
        tick();
        idle();
        tick(); tick();
        free_valid = 1'b1; free_reg = 6'd9;
        tick();
        idle();
        #1;
        checks++; if (frl_r_cp !== 64'h280) begin errors++; $display("FAIL free_forward: got %0h expected 280", frl_r_cp); end
        checks++; if (rob_tail_cp !== 5'd1) begin errors++; $display("FAIL free_entry: got %0d expected 1", rob_tail_cp); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            checks++; if (alloc_id !== IDW'(i % 4)) begin errors++; $display("FAIL wrap_id: step %0d got %0d expected %0d", i, alloc_id, i % 4); end
            alloc_one(RW'(i + 10));
            resolve_valid = 1'b1; resolve_mispredict = 1'b0; resolve_id = IDW'(i % 4);
            tick();
            resolve_valid = 1'b0;
        end
        checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL wrap_empty: got empty %0b full %0b expected 1 0", empty, full); end
        checks++; if (alloc_id !== 2'd2 || dut.head_r !== 2'd2) begin
            errors++; $display("FAIL wrap_ptrs: got tail %0d head %0d expected 2 2", alloc_id, dut.head_r); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_correct_resolve();
        test_mispredict();
        test_mispredict_alloc();
        test_free_forward();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
